systolic_output_accumulator: RTL and testbench
==============================================

Name: systolic_output_accumulator

Overview:
- Sits directly downstream of the 8x8 systolic PE array in TOP_tpu.
- Captures skewed partial sums leaving the bottom of each PE column and deskews them into row order.
- Optionally accumulates them onto the previous tile's results held in an internal register bank.
- Drains completed rows over a valid/ready interface toward the output SRAM writer.

Parameters:
- MATRIX_SIZE, 8, rows and columns per tile (matches NUM_PE_ROWS).
- PSUM_BW, 16, signed partial-sum width per PE column.
- ACC_BW, 24, signed accumulator width per element; must be >= PSUM_BW.

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  synchronous active-low reset.
- start  input  1  one-cycle pulse that begins collection of a tile; honoured only in IDLE.
- acc_mode  input  1  sampled with start. 1 = add to stored value; 0 = overwrite.
- psum_in  input  MATRIX_SIZE*PSUM_BW  column c occupies bits [c*PSUM_BW +: PSUM_BW].
- psum_valid  input  MATRIX_SIZE  bit c qualifies column c this cycle.
- out_row  output  MATRIX_SIZE*ACC_BW  deskewed row; column c occupies [c*ACC_BW +: ACC_BW].
- out_row_idx  output  $clog2(MATRIX_SIZE)  index of the row on out_row.
- out_valid  output  1  out_row/out_row_idx are valid.
- out_ready  input  1  consumer accepts the row when out_valid && out_ready.
- busy  output  1  high in COLLECT or DRAIN.
- done  output  1  one-cycle pulse after the last row handshake.
- err  output  1  sticky protocol error; cleared by reset or by an accepted start.

Behaviour:
- Reset (rstn=0 at posedge): state=IDLE.
  - All accumulators cleared to 0; per-column row counters cleared to 0.
  - out_valid=0, out_row=0, out_row_idx=0, busy=0, done=0, err=0.
  - Reset applied mid-COLLECT or mid-DRAIN aborts the operation with the same result.
- States: IDLE, COLLECT, DRAIN.
- IDLE -> COLLECT on start:
  - Latch acc_mode, zero all column counters, clear err.
  - busy rises the next cycle.
- COLLECT:
  - Each column c keeps its own row counter cnt[c] (0..MATRIX_SIZE).
  - When psum_valid[c]=1 and cnt[c]<MATRIX_SIZE, sign-extend psum_in[c] to ACC_BW and write it to acc[cnt[c]][c]: acc + value if the latched acc_mode=1, else value alone. Then increment cnt[c].
  - The natural array skew (column c row r arrives at t0+r+c) needs no extra alignment; any arrival order per column is accepted.
  - Multiple columns may be valid in the same cycle; all are processed.
  - psum_valid[c]=1 with cnt[c]==MATRIX_SIZE: the sample is dropped, accumulators are unchanged, err is set.
  - COLLECT -> DRAIN the cycle after every cnt[c]==MATRIX_SIZE.
- DRAIN:
  - out_valid=1, out_row_idx starts at 0, out_row = acc[out_row_idx] (registered).
  - On an out_valid&&out_ready handshake, advance the index in the next cycle.
  - out_row and out_row_idx stay stable while out_valid=1 and out_ready=0.
  - After the handshake of row MATRIX_SIZE-1: out_valid=0, done=1 for one cycle, state=IDLE, busy=0.
- Accumulators are retained after DRAIN so a following acc_mode=1 tile sums onto them.
- start outside IDLE: ignored, err set.
- psum_valid outside COLLECT: ignored, no err.
- Arithmetic: two's complement. Without the feature, the sum wraps modulo 2^ACC_BW.
- Latency: the last psum sample is presented on out_row in the 2nd cycle after that sample's edge, when out_ready is held high.

Optional Feature:
- Macro ACC_SATURATE_EN.
- Defined: accumulation saturates to +(2^(ACC_BW-1)-1) or -(2^(ACC_BW-1)). Any element that saturates sets a sticky output sat_flag (1 bit, extra port present only when defined), cleared by reset or by an accepted start.
- Undefined: wrap-around arithmetic, and no sat_flag port.

Test Plan:
- Skewed tile: start with acc_mode=0; column c row r carries value 16*r+c at cycle t0+r+c; out_ready=1 -> rows 0..7 appear on consecutive cycles, element [r][c]=16*r+c; done pulses once; busy returns to 0.
- Accumulate: repeat the previous tile with acc_mode=1 -> element [r][c]=2*(16*r+c). Then a third tile with acc_mode=0 carrying all -1 -> all elements read 0xFFFFFF.
- Backpressure: out_ready toggles 1,0,0,1,... -> no row is skipped or duplicated, rows stay stable while stalled, done follows only the 8th handshake.
- Protocol errors:
  - A 9th psum_valid on column 3 -> sample dropped, err=1, output values unchanged.
  - start pulsed during DRAIN -> ignored, err=1.
  - Next accepted start -> err=0.
- Reset mid-COLLECT after 4 rows -> outputs at reset values; a fresh acc_mode=1 tile of value 5 yields 5 everywhere, proving the accumulators were cleared.
- Overflow: acc_mode=1, preload 0x7FFFF0, then add 0x0020 -> result 0x800010 (wrap) without ACC_SATURATE_EN; with the macro defined, result 0x7FFFFF and sat_flag=1.

Source files
------------

// File: rtl/systolic_output_accumulator_if.sv
// systolic_output_accumulator_if: tile input, row drain and status signals of the output accumulator.
// sat_flag exists only when ACC_SATURATE_EN is defined.
interface systolic_output_accumulator_if #(
    parameter int MATRIX_SIZE = 8,
    parameter int PSUM_BW = 16,
    parameter int ACC_BW = 24
);
    localparam int IW = $clog2(MATRIX_SIZE);
    logic start;
    logic acc_mode;
    logic [MATRIX_SIZE*PSUM_BW-1:0] psum_in;
    logic [MATRIX_SIZE-1:0] psum_valid;
    logic [MATRIX_SIZE*ACC_BW-1:0] out_row;
    logic [IW-1:0] out_row_idx;
    logic out_valid;
    logic out_ready;
    logic busy;
    logic done;
    logic err;
`ifdef ACC_SATURATE_EN
    logic sat_flag;
`endif
    modport master (
        output start, acc_mode, psum_in, psum_valid, out_ready,
        input out_row, out_row_idx, out_valid, busy, done, err
`ifdef ACC_SATURATE_EN
        , input sat_flag
`endif
    );
    modport slave (
        input start, acc_mode, psum_in, psum_valid, out_ready,
        output out_row, out_row_idx, out_valid, busy, done, err
`ifdef ACC_SATURATE_EN
        , output sat_flag
`endif
    );
endinterface

// File: rtl/systolic_output_accumulator.sv
// systolic_output_accumulator: deskews PE-column partial sums into rows, optionally accumulates, drains rows.
// Define ACC_SATURATE_EN for saturating accumulation and the sticky sat_flag output.
module systolic_output_accumulator #(
    parameter int MATRIX_SIZE = 8,
    parameter int PSUM_BW = 16,
    parameter int ACC_BW = 24
) (
    input logic clk,
    input logic rstn,
    systolic_output_accumulator_if.slave bus
);
    localparam int IW = $clog2(MATRIX_SIZE);
    localparam int CW = $clog2(MATRIX_SIZE + 1);
`ifdef ACC_SATURATE_EN
    localparam int SW = ACC_BW + 1;
`else
    localparam int SW = ACC_BW;
`endif
    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;
    state_t state, state_nxt;
    logic mode, done_q, err_q, all_full, accept, hs, last;
    logic [IW-1:0] idx, rd_idx;
    logic [CW-1:0] cnt [MATRIX_SIZE];
    logic [ACC_BW-1:0] acc [MATRIX_SIZE][MATRIX_SIZE];
    logic [SW-1:0] sum [MATRIX_SIZE];
    logic [ACC_BW-1:0] wr_val [MATRIX_SIZE];
    logic [MATRIX_SIZE-1:0] wr_en, drop;
    logic [MATRIX_SIZE*ACC_BW-1:0] row, rd_row;
`ifdef ACC_SATURATE_EN
    logic [MATRIX_SIZE-1:0] sat;
    logic sat_q;
`endif

    always_ff @(posedge clk)
        state <= !rstn ? IDLE : state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: state_nxt = bus.start ? COLLECT : IDLE;
            COLLECT: state_nxt = all_full ? DRAIN : COLLECT;
            DRAIN: state_nxt = hs && last ? IDLE : DRAIN;
            default: state_nxt = IDLE;
        endcase
    end

    // Each column writes the row slot its own counter points at, so skew needs no alignment.
    always_comb begin
        accept = state == IDLE && bus.start;
        hs = state == DRAIN && bus.out_ready;
        last = idx == IW'(MATRIX_SIZE - 1);
        rd_idx = state == DRAIN ? idx + IW'(1) : '0;
        all_full = 1'b1;
        for (int c = 0; c < MATRIX_SIZE; c++) begin
            all_full = all_full && cnt[c] == CW'(MATRIX_SIZE);
            wr_en[c] = state == COLLECT && bus.psum_valid[c] && cnt[c] != CW'(MATRIX_SIZE);
            drop[c] = state == COLLECT && bus.psum_valid[c] && cnt[c] == CW'(MATRIX_SIZE);
            sum[c] = (mode ? SW'($signed(acc[cnt[c][IW-1:0]][c])) : '0)
                   + SW'($signed(bus.psum_in[c*PSUM_BW +: PSUM_BW]));
`ifdef ACC_SATURATE_EN
            sat[c] = wr_en[c] && sum[c][ACC_BW] != sum[c][ACC_BW-1];
            wr_val[c] = !sat[c] ? sum[c][ACC_BW-1:0]
                      : sum[c][ACC_BW] ? {1'b1, {(ACC_BW-1){1'b0}}} : {1'b0, {(ACC_BW-1){1'b1}}};
`else
            wr_val[c] = sum[c];
`endif
        end
        for (int c = 0; c < MATRIX_SIZE; c++)
            rd_row[c*ACC_BW +: ACC_BW] = acc[rd_idx][c];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            mode <= 1'b0;
            done_q <= 1'b0;
            err_q <= 1'b0;
            idx <= '0;
            row <= '0;
`ifdef ACC_SATURATE_EN
            sat_q <= 1'b0;
`endif
            for (int c = 0; c < MATRIX_SIZE; c++)
                cnt[c] <= '0;
            for (int r = 0; r < MATRIX_SIZE; r++)
                for (int c = 0; c < MATRIX_SIZE; c++)
                    acc[r][c] <= '0;
        end else begin
            done_q <= hs && last;
            if (accept)
                mode <= bus.acc_mode;
            err_q <= !accept && (err_q || bus.start || |drop);
`ifdef ACC_SATURATE_EN
            sat_q <= !accept && (sat_q || |sat);
`endif
            // Row register preloads row 0 on entry to DRAIN, then the next row on each handshake.
            if (state == COLLECT && all_full || hs) begin
                idx <= rd_idx;
                row <= rd_row;
            end
            for (int c = 0; c < MATRIX_SIZE; c++) begin
                if (accept)
                    cnt[c] <= '0;
                else if (wr_en[c]) begin
                    cnt[c] <= cnt[c] + CW'(1);
                    acc[cnt[c][IW-1:0]][c] <= wr_val[c];
                end
            end
        end
    end

    always_comb begin
        bus.busy = state != IDLE;
        bus.out_valid = state == DRAIN;
        bus.out_row = row;
        bus.out_row_idx = idx;
        bus.done = done_q;
        bus.err = err_q;
`ifdef ACC_SATURATE_EN
        bus.sat_flag = sat_q;
`endif
    end
endmodule

// File: tb/tb_systolic_output_accumulator.sv
// tb_systolic_output_accumulator: directed tiles with a row scoreboard checked by a separate monitor.
module tb_systolic_output_accumulator;
    localparam int N = 8;
    typedef struct packed {
        logic [2:0] idx;
        logic [191:0] row;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int tiles = 0;
    bit bp_en = 1'b0;
    int bp_k = 0;
    logic [3:0] bp_pat = 4'b1001;
    logic [15:0] tv [N][N];
    logic [23:0] ev [N][N];
    exp_t exp_q[$];

    systolic_output_accumulator_if bus ();
    systolic_output_accumulator dut (.clk(clk), .rstn(rstn), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [191:0] got, input logic [191:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [191:0] pack(input int r);
        logic [191:0] v;
        for (int c = 0; c < N; c++)
            v[c*24 +: 24] = ev[r][c];
        return v;
    endfunction

    task automatic push_exp();
        for (int r = 0; r < N; r++)
            exp_q.push_back('{idx: 3'(r), row: pack(r)});
    endtask

    task automatic send_tile(input logic mode, input int nt, input bit inj);
        bus.start = 1'b1;
        bus.acc_mode = mode;
        tick();
        bus.start = 1'b0;
        bus.acc_mode = 1'b0;
        chk("busy_after_start", 192'(bus.busy), 192'(1));
        chk("err_clr_on_start", 192'(bus.err), 192'(0));
        for (int t = 0; t < nt; t++) begin
            logic [127:0] pi;
            logic [7:0] pv;
            pi = '0;
            pv = '0;
            for (int c = 0; c < N; c++)
                if (t - c >= 0 && t - c < N) begin
                    pv[c] = 1'b1;
                    pi[c*16 +: 16] = tv[t-c][c];
                end
            if (inj && t == 12) begin
                pv[3] = 1'b1;
                pi[3*16 +: 16] = 16'h7777;
            end
            bus.psum_in = pi;
            bus.psum_valid = pv;
            tick();
        end
        bus.psum_valid = '0;
        bus.psum_in = '0;
        tick();
    endtask

    task automatic wait_done(input int n);
        int k = 0;
        while (done_cnt < n && k < 300) begin
            tick();
            k++;
        end
        chk("done_count", 192'(done_cnt), 192'(n));
        chk("queue_drained", 192'(exp_q.size()), 192'(0));
        chk("busy_idle", 192'(bus.busy), 192'(0));
    endtask

    task automatic run_tile(input logic mode, input bit inj);
        push_exp();
        send_tile(mode, 15, inj);
        tiles++;
        wait_done(tiles);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 192'(bus.out_valid), 192'(0));
        chk({tag, "_out_row"}, bus.out_row, 192'(0));
        chk({tag, "_out_row_idx"}, 192'(bus.out_row_idx), 192'(0));
        chk({tag, "_busy"}, 192'(bus.busy), 192'(0));
        chk({tag, "_done"}, 192'(bus.done), 192'(0));
        chk({tag, "_err"}, 192'(bus.err), 192'(0));
    endtask

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = bp_en ? bp_pat[bp_k % 4] : 1'b1;
            bp_k++;
        end
    end

    // Every presented row, stalled or not, must equal the scoreboard head.
    always @(negedge clk) if (rstn) begin
        if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL row_unexpected got idx=%0d row=%0h exp=none", bus.out_row_idx, bus.out_row);
            end else begin
                chk("row_idx", 192'(bus.out_row_idx), 192'(exp_q[0].idx));
                chk("row_data", bus.out_row, exp_q[0].row);
                if (bus.out_ready)
                    void'(exp_q.pop_front());
            end
        end
        if (bus.done) begin
            done_cnt++;
            chk("done_after_last_row", 192'(exp_q.size()), 192'(0));
            chk("done_valid_low", 192'(bus.out_valid), 192'(0));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0;
        bus.acc_mode = 1'b0;
        bus.psum_in = '0;
        bus.psum_valid = '0;
        repeat (3) tick();
        chk_reset_outputs("reset");
        rstn = 1'b1;
        tick();

        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                tv[r][c] = 16'(16 * r + c);
                ev[r][c] = 24'(16 * r + c);
            end
        push_exp();
        send_tile(1'b0, 15, 1'b0);
        chk("latency_valid", 192'(bus.out_valid), 192'(1));
        chk("latency_idx", 192'(bus.out_row_idx), 192'(0));
        repeat (7) tick();
        chk("consec_idx7", 192'(bus.out_row_idx), 192'(7));
        chk("consec_valid7", 192'(bus.out_valid), 192'(1));
        tick();
        chk("end_valid", 192'(bus.out_valid), 192'(0));
        chk("end_done", 192'(bus.done), 192'(1));
        tiles++;
        wait_done(tiles);

        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                ev[r][c] = 24'(2 * (16 * r + c));
        run_tile(1'b1, 1'b0);

        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                tv[r][c] = 16'hFFFF;
                ev[r][c] = 24'hFFFFFF;
            end
        run_tile(1'b0, 1'b0);

        bp_en = 1'b1;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                tv[r][c] = 16'(100 * r - 7 * c);
                ev[r][c] = 24'(100 * r - 7 * c);
            end
        push_exp();
        send_tile(1'b0, 15, 1'b0);
        bus.start = 1'b1;
        bus.acc_mode = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.acc_mode = 1'b0;
        chk("start_in_drain_err", 192'(bus.err), 192'(1));
        chk("start_in_drain_busy", 192'(bus.busy), 192'(1));
        tiles++;
        wait_done(tiles);
        bp_en = 1'b0;

        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                tv[r][c] = 16'(1000 + r - c);
                ev[r][c] = 24'(1000 + r - c);
            end
        run_tile(1'b0, 1'b1);
        chk("ninth_sample_err", 192'(bus.err), 192'(1));

        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                tv[r][c] = 16'd9;
        send_tile(1'b0, 4, 1'b0);
        rstn = 1'b0;
        tick();
        chk_reset_outputs("midreset");
        rstn = 1'b1;
        tick();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                tv[r][c] = 16'd5;
                ev[r][c] = 24'd5;
            end
        run_tile(1'b1, 1'b0);

        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                tv[r][c] = 16'h00F0;
                ev[r][c] = 24'h0000F0;
            end
        run_tile(1'b0, 1'b0);
        for (int k = 1; k <= 256; k++) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) begin
                    tv[r][c] = 16'h7FFF;
                    ev[r][c] = 24'(240 + k * 32767);
                end
            run_tile(1'b1, 1'b0);
        end
`ifdef ACC_SATURATE_EN
        chk("sat_flag_before", 192'(bus.sat_flag), 192'(0));
`endif
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                tv[r][c] = 16'h0020;
`ifdef ACC_SATURATE_EN
                ev[r][c] = 24'h7FFFFF;
`else
                ev[r][c] = 24'h800010;
`endif
            end
        run_tile(1'b1, 1'b0);
`ifdef ACC_SATURATE_EN
        chk("sat_flag_after", 192'(bus.sat_flag), 192'(1));
`endif
        chk("final_err", 192'(bus.err), 192'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
